// File: rtl/ex_seq_ctrl.sv
// Execute-stage sequencer: single-cycle logic ops, iterative shifts on one shared
// shifter, and a one-entry result register with valid/ready toward MEM.
module ex_seq_ctrl #(
  parameter int DATA_W     = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_in,
  input  logic              rdE_in,
  input  logic [4:0]        rdIdx_in,
  input  logic [DATA_W-1:0] rs1Data_in,
  input  logic [DATA_W-1:0] rs2Data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rdE_out,
  output logic [4:0]        rdIdx_out,
  output logic [DATA_W-1:0] rdData_out,
  output logic              stall_out,
  output logic              busy_out
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  sh_val_q, sh_val_d;
  logic [4:0]                sh_rem_q, sh_rem_d;
  logic [2:0]                sh_op_q, sh_op_d;
  logic                      sh_rdE_q, sh_rdE_d;
  logic [4:0]                sh_rdIdx_q, sh_rdIdx_d;
  logic                      out_valid_q, out_valid_d;
  logic                      rdE_q, rdE_d;
  logic [4:0]                rdIdx_q, rdIdx_d;
  logic signed [DATA_W-1:0]  rdData_q, rdData_d;

  logic                      accept;
  logic [4:0]                step_amt;
  logic [4:0]                shamt_in;
  logic                      is_shift_in;
  logic signed [DATA_W-1:0]  sh_next;

  function automatic logic signed [DATA_W-1:0] shift_by(
    input logic [2:0]               op,
    input logic signed [DATA_W-1:0] v,
    input logic [4:0]               amt
  );
    case (op)
      3'd3:    return v << amt;
      3'd4:    return v >> amt;
      3'd5:    return v >>> amt;
      default: return v;
    endcase
  endfunction

  // Results that complete in the accept cycle; zero-amount shifts pass rs1 through.
  function automatic logic signed [DATA_W-1:0] direct_result(
    input logic [2:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    case (op)
      3'd0:             return a ^ b;
      3'd1:             return a | b;
      3'd2:             return a & b;
      3'd3, 3'd4, 3'd5: return a;
      default:          return '0;
    endcase
  endfunction

  assign out_valid  = out_valid_q;
  assign rdE_out    = rdE_q;
  assign rdIdx_out  = rdIdx_q;
  assign rdData_out = rdData_q;
  assign busy_out   = (state_q == S_SHIFT);
  assign stall_out  = in_valid & ~in_ready;

  always_comb begin
    in_ready    = ~flush_in & ((state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready));
    accept      = in_valid & in_ready;
    shamt_in    = rs2Data_in[4:0];
    is_shift_in = (op_in == 3'd3) | (op_in == 3'd4) | (op_in == 3'd5);
    step_amt    = (sh_rem_q < STEP) ? sh_rem_q : STEP;
    sh_next     = shift_by(sh_op_q, sh_val_q, step_amt);

    state_d     = state_q;
    sh_val_d    = sh_val_q;
    sh_rem_d    = sh_rem_q;
    sh_op_d     = sh_op_q;
    sh_rdE_d    = sh_rdE_q;
    sh_rdIdx_d  = sh_rdIdx_q;
    out_valid_d = out_valid_q;
    rdE_d       = rdE_q;
    rdIdx_d     = rdIdx_q;
    rdData_d    = rdData_q;

    if (flush_in) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      rdE_d       = 1'b0;
    end else begin
      case (state_q)
        S_SHIFT: begin
          sh_val_d = sh_next;
          sh_rem_d = sh_rem_q - step_amt;
          // The step that consumes the last remaining bits also writes the result.
          if (sh_rem_q == step_amt) begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
            rdE_d       = sh_rdE_q;
            rdIdx_d     = sh_rdIdx_q;
            rdData_d    = sh_next;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            rdE_d       = 1'b0;
          end
        end
        default: ;
      endcase

      if (accept) begin
        if (is_shift_in && (shamt_in != 5'd0)) begin
          state_d     = S_SHIFT;
          out_valid_d = 1'b0;
          rdE_d       = 1'b0;
          sh_val_d    = rs1Data_in;
          sh_rem_d    = shamt_in;
          sh_op_d     = op_in;
          sh_rdE_d    = rdE_in & (rdIdx_in != 5'd0);
          sh_rdIdx_d  = rdIdx_in;
        end else begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          rdE_d       = rdE_in & (rdIdx_in != 5'd0);
          rdIdx_d     = rdIdx_in;
          rdData_d    = direct_result(op_in, rs1Data_in, rs2Data_in);
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      rdE_q       <= 1'b0;
      rdIdx_q     <= '0;
      rdData_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      rdE_q       <= rdE_d;
      rdIdx_q     <= rdIdx_d;
      rdData_q    <= rdData_d;
    end
  end

  // Shifter working registers are only meaningful while in SHIFT.
  always_ff @(posedge clk_in) begin
    sh_val_q   <= sh_val_d;
    sh_rem_q   <= sh_rem_d;
    sh_op_q    <= sh_op_d;
    sh_rdE_q   <= sh_rdE_d;
    sh_rdIdx_q <= sh_rdIdx_d;
  end

endmodule

// File: tb/tb_ex_seq_ctrl.sv
// Bench for ex_seq_ctrl: directed scenarios plus randomized traffic against a
// latency/result model; a SHIFT_STEP=4 and a SHIFT_STEP=1 instance share inputs.
module tb_ex_seq_ctrl;

  localparam int STEP4 = 4;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in, in_valid, out_ready, rdE_in;
  logic [2:0]  op_in;
  logic [4:0]  rdIdx_in;
  logic [31:0] rs1Data_in, rs2Data_in;

  logic        in_ready, out_valid, rdE_out, stall_out, busy_out;
  logic [4:0]  rdIdx_out;
  logic [31:0] rdData_out;
  logic        in_ready_1, out_valid_1, rdE_out_1, stall_out_1, busy_out_1;
  logic [4:0]  rdIdx_out_1;
  logic [31:0] rdData_out_1;

  int total = 0;
  int bad   = 0;

  ex_seq_ctrl #(.DATA_W(32), .SHIFT_STEP(STEP4)) dut4 (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .op_in(op_in),
    .rdE_in(rdE_in), .rdIdx_in(rdIdx_in), .rs1Data_in(rs1Data_in), .rs2Data_in(rs2Data_in),
    .out_valid(out_valid), .out_ready(out_ready), .rdE_out(rdE_out),
    .rdIdx_out(rdIdx_out), .rdData_out(rdData_out), .stall_out(stall_out), .busy_out(busy_out)
  );

  ex_seq_ctrl #(.DATA_W(32), .SHIFT_STEP(1)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready_1), .op_in(op_in),
    .rdE_in(rdE_in), .rdIdx_in(rdIdx_in), .rs1Data_in(rs1Data_in), .rs2Data_in(rs2Data_in),
    .out_valid(out_valid_1), .out_ready(out_ready), .rdE_out(rdE_out_1),
    .rdIdx_out(rdIdx_out_1), .rdData_out(rdData_out_1), .stall_out(stall_out_1), .busy_out(busy_out_1)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic we, input logic [4:0] idx,
                        input logic [31:0] a, input logic [31:0] b);
    in_valid   = 1'b1;
    op_in      = op;
    rdE_in     = we;
    rdIdx_in   = idx;
    rs1Data_in = a;
    rs2Data_in = b;
  endtask

  task automatic quiesce();
    in_valid = 1'b0;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int n;
    logic [31:0] r;
    n = int'(b[4:0]);
    case (op)
      3'd0: r = a ^ b;
      3'd1: r = a | b;
      3'd2: r = a & b;
      3'd3: r = a << n;
      3'd4: r = a >> n;
      3'd5: begin
        r = a >> n;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> n);
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst_in = 1'b0; flush_in = 1'b0; out_ready = 1'b1;
    set_op(3'd0, 1'b1, 5'd3, 32'h1234_5678, 32'h0000_00FF);
    tick(); tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || rdE_out !== 1'b0 || rdIdx_out !== 5'd0 || rdData_out !== 32'h0 || busy_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got ov=%b rdE=%b idx=%0d data=%h busy=%b, want all zero",
               out_valid, rdE_out, rdIdx_out, rdData_out, busy_out);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst_in = 1'b1;
    tick();
    #1;
    total++;
    if (out_valid !== 1'b0 || busy_out !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_idle: got ov=%b busy=%b rdy=%b want 0 0 1", out_valid, busy_out, in_ready);
    end
  endtask

  task automatic test_logic();
    out_ready = 1'b1;
    set_op(3'd0, 1'b1, 5'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL logic_idle_ready: got %b want 1", in_ready);
    end
    tick();
    set_op(3'd2, 1'b1, 5'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    #1;
    total++;
    if (out_valid !== 1'b1 || rdData_out !== 32'hFF00_FF00 || rdIdx_out !== 5'd5 || rdE_out !== 1'b1) begin
      bad++;
      $display("FAIL logic_xor: got ov=%b data=%h idx=%0d rdE=%b want 1 ff00ff00 5 1",
               out_valid, rdData_out, rdIdx_out, rdE_out);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL logic_b2b_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || rdData_out !== 32'h00F0_00F0 || rdIdx_out !== 5'd6) begin
      bad++;
      $display("FAIL logic_and: got ov=%b data=%h idx=%0d want 1 00f000f0 6", out_valid, rdData_out, rdIdx_out);
    end
    tick();
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL logic_drain: got ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_shift();
    int cyc, busy_cnt, stall_err;
    out_ready = 1'b1;
    set_op(3'd5, 1'b1, 5'd7, 32'h8000_0000, 32'd31);
    tick();
    set_op(3'd0, 1'b1, 5'd3, 32'h1234_5678, 32'hFFFF_FFFF);
    #1;
    cyc = 1; busy_cnt = 0; stall_err = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      if (busy_out === 1'b1) busy_cnt++;
      if (stall_out !== 1'b1 || in_ready !== 1'b0) stall_err++;
      tick();
      #1;
      cyc++;
    end
    total++;
    if (cyc != 9) begin
      bad++;
      $display("FAIL shift_latency: got %0d cycles want 9", cyc);
    end
    total++;
    if (busy_cnt != 8) begin
      bad++;
      $display("FAIL shift_busy_cycles: got %0d want 8", busy_cnt);
    end
    total++;
    if (stall_err != 0) begin
      bad++;
      $display("FAIL shift_stall: %0d cycles without stall, want 0", stall_err);
    end
    total++;
    if (rdData_out !== 32'hFFFF_FFFF || rdIdx_out !== 5'd7 || rdE_out !== 1'b1) begin
      bad++;
      $display("FAIL shift_sra_result: got data=%h idx=%0d rdE=%b want ffffffff 7 1", rdData_out, rdIdx_out, rdE_out);
    end
    total++;
    if (in_ready !== 1'b1 || stall_out !== 1'b0) begin
      bad++;
      $display("FAIL shift_queued_accept: got rdy=%b stall=%b want 1 0", in_ready, stall_out);
    end
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || rdData_out !== 32'hEDCB_A987 || rdIdx_out !== 5'd3) begin
      bad++;
      $display("FAIL shift_queued_result: got ov=%b data=%h idx=%0d want 1 edcba987 3", out_valid, rdData_out, rdIdx_out);
    end
    tick();
  endtask

  task automatic test_backpressure();
    quiesce();
    out_ready = 1'b1;
    set_op(3'd1, 1'b1, 5'd9, 32'h1, 32'h2);
    tick();
    set_op(3'd2, 1'b1, 5'd10, 32'hFF, 32'h0F);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (out_valid !== 1'b1 || rdData_out !== 32'h3 || rdIdx_out !== 5'd9 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got ov=%b data=%h idx=%0d rdy=%b want 1 3 9 0",
                 i, out_valid, rdData_out, rdIdx_out, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || rdData_out !== 32'h3) begin
      bad++;
      $display("FAIL bp_release: got rdy=%b ov=%b data=%h want 1 1 3", in_ready, out_valid, rdData_out);
    end
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || rdData_out !== 32'h0F || rdIdx_out !== 5'd10) begin
      bad++;
      $display("FAIL bp_same_edge_accept: got ov=%b data=%h idx=%0d want 1 f 10", out_valid, rdData_out, rdIdx_out);
    end
    tick();
  endtask

  task automatic test_flush();
    int seen;
    quiesce();
    out_ready = 1'b1;
    set_op(3'd3, 1'b1, 5'd4, 32'h1, 32'd20);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #1;
    total++;
    if (busy_out_1 !== 1'b1) begin
      bad++;
      $display("FAIL flush_pre_busy: got %b want 1", busy_out_1);
    end
    flush_in = 1'b1;
    set_op(3'd0, 1'b1, 5'd8, 32'h5, 32'h6);
    #1;
    total++;
    if (in_ready_1 !== 1'b0 || stall_out_1 !== 1'b1) begin
      bad++;
      $display("FAIL flush_blocks_input: got rdy=%b stall=%b want 0 1", in_ready_1, stall_out_1);
    end
    tick();
    flush_in = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if (busy_out_1 !== 1'b0 || out_valid_1 !== 1'b0 || in_ready_1 !== 1'b1) begin
      bad++;
      $display("FAIL flush_to_idle: got busy=%b ov=%b rdy=%b want 0 0 1", busy_out_1, out_valid_1, in_ready_1);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid_1 === 1'b1 || out_valid === 1'b1) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL flush_no_result: got %0d valid cycles want 0", seen);
    end
    out_ready = 1'b0;
    set_op(3'd0, 1'b1, 5'd11, 32'hAAAA_AAAA, 32'h5555_5555);
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid_1 !== 1'b1 || rdData_out_1 !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL flush_setup_hold: got ov=%b data=%h want 1 ffffffff", out_valid_1, rdData_out_1);
    end
    rst_in = 1'b0;
    flush_in = 1'b1;
    tick();
    #1;
    total++;
    if (out_valid_1 !== 1'b0 || rdE_out_1 !== 1'b0 || rdIdx_out_1 !== 5'd0 || rdData_out_1 !== 32'h0) begin
      bad++;
      $display("FAIL reset_with_flush: got ov=%b rdE=%b idx=%0d data=%h want all zero",
               out_valid_1, rdE_out_1, rdIdx_out_1, rdData_out_1);
    end
    rst_in = 1'b1;
    flush_in = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_edges();
    out_ready = 1'b1;
    set_op(3'd0, 1'b1, 5'd0, 32'h5, 32'h3);
    tick();
    set_op(3'd3, 1'b1, 5'd12, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    #1;
    total++;
    if (out_valid !== 1'b1 || rdE_out !== 1'b0 || rdIdx_out !== 5'd0 || rdData_out !== 32'h6) begin
      bad++;
      $display("FAIL edge_rd0: got ov=%b rdE=%b idx=%0d data=%h want 1 0 0 6", out_valid, rdE_out, rdIdx_out, rdData_out);
    end
    tick();
    set_op(3'd7, 1'b1, 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    total++;
    if (out_valid !== 1'b1 || rdData_out !== 32'hDEAD_BEEF || rdIdx_out !== 5'd12 || rdE_out !== 1'b1) begin
      bad++;
      $display("FAIL edge_sll0: got ov=%b data=%h idx=%0d rdE=%b want 1 deadbeef 12 1",
               out_valid, rdData_out, rdIdx_out, rdE_out);
    end
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || rdData_out !== 32'h0 || rdIdx_out !== 5'd13) begin
      bad++;
      $display("FAIL edge_op7: got ov=%b data=%h idx=%0d want 1 0 13", out_valid, rdData_out, rdIdx_out);
    end
    tick();
  endtask

  task automatic test_random();
    bit          m_has;
    int          m_rdy, t, n, lat;
    logic [31:0] m_data;
    logic [4:0]  m_idx;
    logic        m_rdE;
    bit          e_ov, e_ir, e_busy, e_stall;
    quiesce();
    m_has = 0; m_rdy = 0; m_data = '0; m_idx = '0; m_rdE = 0;
    for (t = 0; t < 600; t++) begin
      in_valid   = ($urandom_range(0, 99) < 60);
      op_in      = 3'($urandom_range(0, 7));
      rdE_in     = 1'($urandom_range(0, 1));
      rdIdx_in   = 5'($urandom_range(0, 31));
      rs1Data_in = $urandom;
      rs2Data_in = $urandom;
      out_ready  = ($urandom_range(0, 99) < 70);
      flush_in   = ($urandom_range(0, 99) < 3);
      #1;
      e_ov    = m_has && (t >= m_rdy);
      e_ir    = !flush_in && (!m_has || (e_ov && out_ready));
      e_busy  = m_has && !e_ov;
      e_stall = in_valid && !e_ir;
      total++;
      if (out_valid !== e_ov || in_ready !== e_ir || busy_out !== e_busy || stall_out !== e_stall) begin
        bad++;
        $display("FAIL rand_ctrl t=%0d: got ov=%b rdy=%b busy=%b stall=%b want %b %b %b %b",
                 t, out_valid, in_ready, busy_out, stall_out, e_ov, e_ir, e_busy, e_stall);
      end
      if (e_ov) begin
        total++;
        if (rdData_out !== m_data || rdIdx_out !== m_idx || rdE_out !== m_rdE) begin
          bad++;
          $display("FAIL rand_data t=%0d: got data=%h idx=%0d rdE=%b want %h %0d %b",
                   t, rdData_out, rdIdx_out, rdE_out, m_data, m_idx, m_rdE);
        end
      end
      if (flush_in) begin
        m_has = 0;
      end else if (in_valid && e_ir) begin
        n   = int'(rs2Data_in[4:0]);
        lat = (op_in >= 3'd3 && op_in <= 3'd5 && n > 0) ? 1 + (n + STEP4 - 1) / STEP4 : 1;
        m_has  = 1;
        m_rdy  = t + lat;
        m_data = ref_res(op_in, rs1Data_in, rs2Data_in);
        m_idx  = rdIdx_in;
        m_rdE  = rdE_in && (rdIdx_in != 5'd0);
      end else if (e_ov && out_ready) begin
        m_has = 0;
      end
      tick();
    end
    in_valid = 1'b0;
    flush_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_logic();
    test_shift();
    test_backpressure();
    test_flush();
    quiesce();
    test_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
